// File: rtl/wired_or_gather_arbiter.sv
// wired_or_gather_arbiter
//   Gathers 32-bit words from 32 sources onto one registered output.
//   A round-robin arbiter picks one requester. Its one-hot grant gates each
//   source word, and the OR of the gated words (wired-OR) is captured together
//   with the 5-bit winner index.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req[31:0]             per-source request (X/Z counts as not requesting)
//   indata0..indata31     per-source data, held stable until granted
//   grant[31:0]           one-hot acknowledge, pulses the cycle after capture
//   outdata[31:0]         captured word
//   outsel[4:0]           index of the source that supplied outdata
//   outvalid / outready   output handshake (transfer on outvalid && outready)
//   outparity             even parity of outdata (only with GATHER_PARITY_EN)
//
// Configuration macro: GATHER_PARITY_EN adds the registered outparity output.
module wired_or_gather_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] req,
  input  logic [31:0] indata0,  indata1,  indata2,  indata3,
  input  logic [31:0] indata4,  indata5,  indata6,  indata7,
  input  logic [31:0] indata8,  indata9,  indata10, indata11,
  input  logic [31:0] indata12, indata13, indata14, indata15,
  input  logic [31:0] indata16, indata17, indata18, indata19,
  input  logic [31:0] indata20, indata21, indata22, indata23,
  input  logic [31:0] indata24, indata25, indata26, indata27,
  input  logic [31:0] indata28, indata29, indata30, indata31,
  output logic [31:0] grant,
  output logic [31:0] outdata,
  output logic [4:0]  outsel,
`ifdef GATHER_PARITY_EN
  output logic        outparity,
`endif
  output logic        outvalid,
  input  logic        outready
);

  localparam int NSRC = 32;
  localparam int DW   = 32;

  logic [DW-1:0] src [NSRC];

  assign src[0]  = indata0;  assign src[1]  = indata1;
  assign src[2]  = indata2;  assign src[3]  = indata3;
  assign src[4]  = indata4;  assign src[5]  = indata5;
  assign src[6]  = indata6;  assign src[7]  = indata7;
  assign src[8]  = indata8;  assign src[9]  = indata9;
  assign src[10] = indata10; assign src[11] = indata11;
  assign src[12] = indata12; assign src[13] = indata13;
  assign src[14] = indata14; assign src[15] = indata15;
  assign src[16] = indata16; assign src[17] = indata17;
  assign src[18] = indata18; assign src[19] = indata19;
  assign src[20] = indata20; assign src[21] = indata21;
  assign src[22] = indata22; assign src[23] = indata23;
  assign src[24] = indata24; assign src[25] = indata25;
  assign src[26] = indata26; assign src[27] = indata27;
  assign src[28] = indata28; assign src[29] = indata29;
  assign src[30] = indata30; assign src[31] = indata31;

  logic [4:0]    last;       // most recent winner; search starts just above it
  logic [4:0]    winner;
  logic [4:0]    cand;
  logic          found;
  logic          load;
  logic [31:0]   g;
  logic [DW-1:0] combined;

  // Round-robin search: offsets 1..32 from last, wrapping mod 32, so that
  // last itself is visited at the very end. The first requester wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    found  = 1'b0;
    winner = last;
    cand   = '0;
    for (int k = 1; k <= NSRC; k++) begin
      cand = last + 5'(k);
      // === keeps X/Z request bits from being treated as requests.
      if (!found && (req[cand] === 1'b1)) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // found is the X-safe form of |req.
  assign load = found && (!outvalid || outready);
  assign g    = load ? (32'd1 << winner) : '0;

  // Wired-OR gather: only the granted term is non-zero.
  always_comb begin
    combined = '0;
    for (int i = 0; i < NSRC; i++) begin
      combined = combined | (src[i] & {DW{g[i]}});
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last     <= 5'd31;
      grant    <= '0;
      outdata  <= '0;
      outsel   <= '0;
      outvalid <= 1'b0;
    end else begin
      grant <= g;
      if (load) begin
        last     <= winner;
        outdata  <= combined;
        outsel   <= winner;
        outvalid <= 1'b1;
      end else if (outvalid && outready) begin
        outvalid <= 1'b0;
      end
    end
  end

`ifdef GATHER_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outparity <= 1'b0;
    end else if (load) begin
      outparity <= ^combined;
    end
  end
`endif

endmodule

// File: tb/tb_wired_or_gather_arbiter.sv
// Self-checking bench for wired_or_gather_arbiter. The stimulus process
// pushes the expected word into a scoreboard queue. A monitor on the falling
// edge pops and compares it whenever a transfer (outvalid && outready) is
// presented. Grant and stall behaviour is checked directly from the stimulus.
module tb_wired_or_gather_arbiter;

  typedef struct {
    logic [4:0]  sel;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] req;
  logic [31:0] tb_data [32];
  logic [31:0] grant;
  logic [31:0] outdata;
  logic [4:0]  outsel;
  logic        outvalid;
  logic        outready;
`ifdef GATHER_PARITY_EN
  logic        outparity;
`endif

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  wired_or_gather_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .indata0(tb_data[0]),   .indata1(tb_data[1]),   .indata2(tb_data[2]),   .indata3(tb_data[3]),
    .indata4(tb_data[4]),   .indata5(tb_data[5]),   .indata6(tb_data[6]),   .indata7(tb_data[7]),
    .indata8(tb_data[8]),   .indata9(tb_data[9]),   .indata10(tb_data[10]), .indata11(tb_data[11]),
    .indata12(tb_data[12]), .indata13(tb_data[13]), .indata14(tb_data[14]), .indata15(tb_data[15]),
    .indata16(tb_data[16]), .indata17(tb_data[17]), .indata18(tb_data[18]), .indata19(tb_data[19]),
    .indata20(tb_data[20]), .indata21(tb_data[21]), .indata22(tb_data[22]), .indata23(tb_data[23]),
    .indata24(tb_data[24]), .indata25(tb_data[25]), .indata26(tb_data[26]), .indata27(tb_data[27]),
    .indata28(tb_data[28]), .indata29(tb_data[29]), .indata30(tb_data[30]), .indata31(tb_data[31]),
    .grant(grant), .outdata(outdata), .outsel(outsel),
`ifdef GATHER_PARITY_EN
    .outparity(outparity),
`endif
    .outvalid(outvalid), .outready(outready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] sel, input logic [31:0] data);
    exp_t e;
    e.sel  = sel;
    e.data = data;
    sb.push_back(e);
  endtask

  // Monitor: outputs are stable at the falling edge, and a transfer takes
  // place at the following rising edge.
  always @(negedge clk) begin
    if (rst_n && outvalid && outready) begin
      if (sb.size() == 0) begin
        check("unexpected_word", {27'd0, outsel}, 64'hFFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("outsel", {59'd0, outsel}, {59'd0, e.sel});
        check("outdata", {32'd0, outdata}, {32'd0, e.data});
`ifdef GATHER_PARITY_EN
        check("outparity", {63'd0, outparity}, {63'd0, ^e.data});
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n    = 1'b0;
    req      = '0;
    outready = 1'b1;
    for (int i = 0; i < 32; i++) tb_data[i] = '0;

    // Reset, then idle.
    step(); step();
    check("rst_outvalid", {63'd0, outvalid}, 64'd0);
    check("rst_grant", {32'd0, grant}, 64'd0);
    check("rst_outsel", {59'd0, outsel}, 64'd0);
    check("rst_outdata", {32'd0, outdata}, 64'd0);
    rst_n = 1'b1;
    repeat (3) step();
    check("idle_outvalid", {63'd0, outvalid}, 64'd0);
    check("idle_grant", {32'd0, grant}, 64'd0);

    // Single source 5.
    tb_data[5] = 32'hDEADBEEF;
    req = 32'h0000_0020;
    push(5'd5, 32'hDEADBEEF);
    step();
    req = '0;
    check("single_grant", {32'd0, grant}, 64'h20);
    check("single_valid", {63'd0, outvalid}, 64'd1);
    step();
    check("single_drain_valid", {63'd0, outvalid}, 64'd0);
    check("single_drain_grant", {32'd0, grant}, 64'd0);

    // Wired-OR isolation: idle sources hold all ones.
    for (int i = 0; i < 32; i++) tb_data[i] = 32'hFFFF_FFFF;
    tb_data[3] = 32'h0000_00F0;
    req = 32'h0000_0008;
    push(5'd3, 32'h0000_00F0);
    step();
    req = '0;
    check("iso_grant", {32'd0, grant}, 64'h8);
    step();

    // Round-robin from a fresh reset: outsel 0,1,...,31,0.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) tb_data[i] = 32'hA500_0000 | i;
    req = 32'hFFFF_FFFF;
    for (int k = 0; k < 33; k++) begin
      push(5'(k % 32), 32'hA500_0000 | (k % 32));
      step();
      check($sformatf("rr_grant_%0d", k), {32'd0, grant}, 64'd1 << (k % 32));
    end

    // Wrap: make last = 30, then 31 beats 2, then 2 wins.
    req = 32'h4000_0000;
    push(5'd30, tb_data[30]);
    step();
    check("wrap_grant30", {32'd0, grant}, 64'h4000_0000);
    req = 32'h8000_0004;
    push(5'd31, tb_data[31]);
    step();
    check("wrap_grant31", {32'd0, grant}, 64'h8000_0000);
    req = 32'h0000_0004;
    push(5'd2, tb_data[2]);
    step();
    check("wrap_grant2", {32'd0, grant}, 64'h4);
    req = '0;
    step();
    check("wrap_drain_valid", {63'd0, outvalid}, 64'd0);

    // Backpressure: source 7 loads, presents a second word, stalls for 4 cycles.
    tb_data[7] = 32'h7777_0001;
    req = 32'h0000_0080;
    outready = 1'b0;
    push(5'd7, 32'h7777_0001);
    step();
    check("bp_first_grant", {32'd0, grant}, 64'h80);
    tb_data[7] = 32'h7777_0002;
    push(5'd7, 32'h7777_0002);
    for (int k = 0; k < 4; k++) begin
      step();
      check("bp_stall_grant", {32'd0, grant}, 64'd0);
      check("bp_stall_outsel", {59'd0, outsel}, 64'd7);
      check("bp_stall_outdata", {32'd0, outdata}, 64'h7777_0001);
      check("bp_stall_valid", {63'd0, outvalid}, 64'd1);
    end
    outready = 1'b1;
    step();
    req = '0;
    check("bp_reload_grant", {32'd0, grant}, 64'h80);
    check("bp_reload_outdata", {32'd0, outdata}, 64'h7777_0002);
    step();
    check("bp_drain_valid", {63'd0, outvalid}, 64'd0);

    // Reset mid-transfer discards the held word.
    tb_data[9] = 32'h9999_9999;
    req = 32'h0000_0200;
    outready = 1'b0;
    step();
    check("mid_loaded_valid", {63'd0, outvalid}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {63'd0, outvalid}, 64'd0);
    check("mid_rst_grant", {32'd0, grant}, 64'd0);
    check("mid_rst_outsel", {59'd0, outsel}, 64'd0);
    req = '0;
    outready = 1'b1;
    step();
    rst_n = 1'b1;
    repeat (3) step();
    check("post_rst_valid", {63'd0, outvalid}, 64'd0);
    check("post_rst_grant", {32'd0, grant}, 64'd0);
    check("post_rst_outdata", {32'd0, outdata}, 64'd0);

    // Wait, bounded, for the scoreboard to drain.
    for (int k = 0; k < 20 && sb.size() != 0; k++) step();
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wired_or_gather_arbiter.md
# wired_or_gather_arbiter

Return-path counterpart to the 1-to-32 data demultiplexer in the wired-OR interconnect: collects 32-bit words from up to 32 sources (tp32 side to ICache side, responses back), arbitrates round-robin, and drives a single registered output with a valid/ready handshake. Selection uses a one-hot grant that gates each source word; the gated words are OR-reduced into one word (wired-OR), and the result is registered together with the 5-bit source index. The block sits between the 32 per-source ports and the single consumer port.

## Interface
- NSRC, 32: number of sources; fixed at 32, with a 5-bit index.
- DW, 32: data width.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  32  per-source request; bit i asserts that indata<i> holds a valid word.
- indata0 … indata31  in  32 each  per-source data; must stay stable while req[i]=1 and grant[i]=0.
- grant  out  32  one-hot acknowledge, one cycle; source i may drop or advance its word in the cycle after grant[i]=1.
- outdata  out  32  registered winning word.
- outsel  out  5  index of the source that supplied outdata.
- outvalid  out  1  outdata/outsel hold a word.
- outready  in  1  consumer accepts the word when outvalid&&outready.

## Operation
- Load condition: `load = (|req) && (!outvalid || outready)`.
- Arbiter: round-robin. The search starts at (last+1) mod 32 and wraps upward; the first requesting index wins. `last` updates to the winner only on load.
- Combinational grant vector g: one-hot of the winner when load=1, else all zero.
- grant is g registered, so grant[i] pulses in the cycle after the capture.
- Combining: `outdata_next = OR over i of (indata<i> & {32{g[i]}})`. Exactly one term is non-zero.
- On load: outdata<=combined word, outsel<=winner index, outvalid<=1.
- Drain without load: outvalid&&outready&&!(|req) -> outvalid<=0; outdata and outsel hold their last value.
- Simultaneous drain and load in the same cycle: the new word replaces the old one. Sustained throughput is 1 word/cycle.
- Stall: outvalid&&!outready -> no load, grant=0, `last` unchanged, outdata and outsel hold.
- A source is never granted twice for the same word: it sees grant[i] before it is eligible again, because it must deassert or present new data after the grant cycle. The requester is responsible for this. The block adds no filtering.
- req bits that are X or Z count as not requesting. Use a ===1 comparison in simulation.

## Timing
- Reset (async assert, sync deassert assumed upstream): outvalid=0, outdata=0, outsel=0, grant=0, last=31, so index 0 has highest priority first.
- Latency: a word presented with req in cycle N appears on outdata/outvalid in cycle N+1 when it wins in N. grant pulses in cycle N+1.
- Worst-case wait under continuous all-source requests and outready=1: 31 cycles.
- Reset asserted mid-transfer: any word in the output register is discarded. No grant is issued for a word that was not captured.
- Wrap-around: with last=31 the search starts at 0. With last=k the search covers k+1 … 31, then 0 … k, so source k is last.

## Configuration
- GATHER_PARITY_EN defined: adds output port outparity (1 bit), registered alongside outdata, equal to the even parity of the captured word, i.e. ^outdata_next. Reset value 0. Held during a stall.
- Not defined: no outparity port, no parity logic.

## Test plan
- Reset then idle: rst_n=0 mid-run with outvalid=1 -> outvalid=0, grant=0, outsel=0 immediately. After release with req=0 all outputs stay 0.
- Single source: req[5]=1, indata5=32'hDEADBEEF, outready=1 -> next cycle outvalid=1, outdata=32'hDEADBEEF, outsel=5, grant[5]=1. With GATHER_PARITY_EN, outparity=0.
- Round-robin fairness: req=32'hFFFFFFFF held, outready=1 -> outsel sequence 0,1,2,…,31,0. Each grant bit pulses once per 32 cycles.
- Wrap: last=30, then req[31] and req[2] both set -> 31 wins. On the next cycle, with only req[2] set, 2 wins.
- Backpressure: outvalid=1, outready=0 for 4 cycles with req[7]=1 -> outdata/outsel stable, grant=0. When outready rises, source 7 is captured in that same cycle (drain plus load) and outsel=7 the next cycle.
- Wired-OR isolation: req[3]=1 with indata3=32'h0000_00F0 and every other indataN=32'hFFFF_FFFF (not requesting) -> outdata=32'h0000_00F0 exactly.
